rr_alu_ctl_seq: RTL and testbench
=================================

# rr_alu_ctl_seq

Parameterised control-step sequencer for the Mini-SRC datapath. It generates the fetch/execute control strobes (T0..T5, plus T6 for multiply/divide) for three-register ALU instructions from the fetched instruction word. It replaces hand-sequenced per-instruction control: one block drives `PCout`, `MARin`, `Zlowout`, register select lines and the rest for any supported R-type opcode. Instruction fetch stalls on a memory-ready handshake.

## Interface
- `DATA_W`, default 32: instruction/datapath width.
- `OPC_W`, default 5: opcode field width, taken from the instruction MSBs.
- `REG_FLD_W`, default 4: width of each register field; `NREGS = 2**REG_FLD_W` (localparam).
- Field layout, contiguous below the opcode:
  - Ra = `ir_in[DATA_W-OPC_W-1 -: REG_FLD_W]`.
  - Rb is the next field down.
  - Rc is the field below Rb.

Ports:
- `Clock` input 1: single clock; all state changes on the rising edge.
- `clear` input 1: reset, synchronous, active-high.
- `start` input 1: begin an instruction; sampled only in IDLE.
- `mem_rdy` input 1: memory data valid during fetch.
- `ir_in` input `DATA_W`: IR register contents, valid from T3 onward.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in the final execute state.
- `err` output 1: one-cycle pulse in T3 for an unsupported opcode.
- `PCout`, `Zlowout`, `Zhighout`, `MDRout`, `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `LOin`, `HIin`, `IncPC`, `Read`: output, 1 bit each; datapath strobes.
- `alu_op` output `OPC_W`: opcode to the ALU. Valid in T4 and later; otherwise 0.
- `reg_in` output `NREGS`: one-hot register write enable.
- `reg_out` output `NREGS`: one-hot register drive enable.

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6 (T6 only with the macro).
- All outputs are Moore-decoded from the registered state plus `ir_in` fields. At most one `reg_out` bit is high.
- Per-state behaviour:
  - **IDLE**: all outputs 0. If `start`=1, go to T0.
  - **T0**: `PCout`, `MARin`, `IncPC`, `Zin` high. Go to T1.
  - **T1**: `Zlowout`, `PCin`, `Read`, `MDRin` high. If `mem_rdy`, go to T2; else go to T1W.
  - **T1W**: only `Read` and `MDRin` high. `PCin` is never repeated. Stay until `mem_rdy`, then go to T2.
  - **T2**: `MDRout`, `IRin` high. Go to T3.
  - **T3**: decode the opcode.
    - Legal opcode: `reg_out[Rb]` and `Yin` high. Go to T4.
    - Illegal opcode: only `err` high. Go to IDLE.
  - **T4**: `reg_out[Rc]`, `Zin` high, `alu_op` = opcode. Go to T5.
  - **T5**: `Zlowout`, `reg_in[Ra]`, `done` high. Go to IDLE.
- Supported opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol. Everything else is illegal.
- Any `start` seen while `busy` is ignored. It is not queued.
- `clear` high: next edge goes to IDLE with all outputs 0, from any state, including mid-stall in T1W.
- `clear` and `start` high together: `clear` wins.

## Timing
- Reset value of every output is 0. State is IDLE.
- With `mem_rdy` tied high: `start` sampled at edge N puts T0 at cycle N+1, and `done` is high at cycle N+6.
- Each cycle `mem_rdy` is low adds one T1W cycle.
- With `mem_rdy` held low, fetch stalls indefinitely with `busy`=1.
- Illegal opcode: `err` is high at cycle N+4, and the block is back in IDLE at N+5.
- Back-to-back: a `start` held high through `done` begins the next T0 on the cycle after the T5 cycle.

## Configuration
- `RR_SEQ_MULDIV_EN` defined:
  - Opcodes 01111 (mul) and 10000 (div) are legal, with operands Ra and Rb.
  - T3: `reg_out[Ra]`, `Yin`.
  - T4: `reg_out[Rb]`, `Zin`, `alu_op`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`, `done`. Then go to IDLE. Latency is 7.
- Not defined:
  - T6 is not generated. Mul/div opcodes give `err`.
  - `LOin`, `HIin`, `Zhighout` are tied to 0.

## Test plan
- `ir_in`=0x20918000 (sub R1,R2,R3), `mem_rdy`=1, pulse `start`:
  - T3: `reg_out`=0x0004.
  - T4: `reg_out`=0x0008, `alu_op`=5'b00100.
  - T5: `reg_in`=0x0002, `done`=1, 6 cycles after the `start` edge.
- Same instruction, `mem_rdy` low for 3 cycles after T1:
  - Exactly 3 T1W cycles with `Read`=`MDRin`=1 and `PCin`=0.
  - `done` arrives 3 cycles later than in the first scenario.
- `ir_in`=0xF8000000 (opcode 11111):
  - `err`=1 for one cycle at T3, no `reg_in`/`reg_out` bit ever set.
  - `busy` drops the next cycle.
- `clear` asserted during T4 of add:
  - Next cycle all outputs 0, `busy`=0.
  - A later `start` runs a full correct sequence.
- With `RR_SEQ_MULDIV_EN`, `ir_in`=0x7A280000 (mul R4,R5):
  - T5: `LOin`=`Zlowout`=1.
  - T6: `HIin`=`Zhighout`=`done`=1.
  - `reg_in` stays 0 throughout.
- `start` pulsed during T2: ignored. Exactly one `done` results.

Source files
------------

// File: rtl/rr_alu_ctl_seq.sv
// Control-step sequencer for Mini-SRC three-register ALU instructions (fetch T0..T2, execute T3..T5).
// Define RR_SEQ_MULDIV_EN to add mul/div sequencing through T6 with LO/HI capture.
module rr_alu_ctl_seq #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned REG_FLD_W = 4,
  localparam int unsigned NREGS    = 2**REG_FLD_W
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] ir_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              PCout,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              MDRout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              LOin,
  output logic              HIin,
  output logic              IncPC,
  output logic              Read,
  output logic [OPC_W-1:0]  alu_op,
  output logic [NREGS-1:0]  reg_in,
  output logic [NREGS-1:0]  reg_out
);

  localparam int unsigned RA_MSB = DATA_W - OPC_W - 1;
  localparam int unsigned RB_MSB = RA_MSB - REG_FLD_W;
  localparam int unsigned RC_MSB = RB_MSB - REG_FLD_W;
  localparam int unsigned RC_LSB = RC_MSB - REG_FLD_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t state, state_nx;

  logic [OPC_W-1:0]     opcode;
  logic [REG_FLD_W-1:0] ra, rb, rc;
  logic                 is_alu, is_muldiv, is_legal;
  logic                 unused_ir_lo;

  assign opcode = ir_in[DATA_W-1 -: OPC_W];
  assign ra     = ir_in[RA_MSB -: REG_FLD_W];
  assign rb     = ir_in[RB_MSB -: REG_FLD_W];
  assign rc     = ir_in[RC_MSB -: REG_FLD_W];
  assign unused_ir_lo = ^ir_in[RC_LSB-1:0];

  // Supported R-type ALU opcodes form the contiguous range add (3) .. rol (11).
  assign is_alu = (opcode >= OPC_W'(3)) && (opcode <= OPC_W'(11));

`ifdef RR_SEQ_MULDIV_EN
  assign is_muldiv = (opcode == OPC_W'(15)) || (opcode == OPC_W'(16));
`else
  assign is_muldiv = 1'b0;
`endif

  assign is_legal = is_alu || is_muldiv;

  function automatic logic [NREGS-1:0] onehot(input logic [REG_FLD_W-1:0] idx);
    return NREGS'(1) << idx;
  endfunction

  // State register with synchronous clear.
  always_ff @(posedge Clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and Moore strobe decode from state plus IR fields.
  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    alu_op   = '0;
    reg_in   = '0;
    reg_out  = '0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_T0;
      end
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        Zin      = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        Read     = 1'b1;
        MDRin    = 1'b1;
        state_nx = mem_rdy ? S_T2 : S_T1W;
      end
      // Fetch stall: keep reading, but the incremented PC was already loaded in T1.
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_rdy) state_nx = S_T2;
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        if (is_legal) begin
          Yin      = 1'b1;
          reg_out  = is_muldiv ? onehot(ra) : onehot(rb);
          state_nx = S_T4;
        end else begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_T4: begin
        Zin      = 1'b1;
        alu_op   = opcode;
        reg_out  = is_muldiv ? onehot(rb) : onehot(rc);
        state_nx = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        alu_op  = opcode;
`ifdef RR_SEQ_MULDIV_EN
        if (is_muldiv) begin
          LOin     = 1'b1;
          state_nx = S_T6;
        end else begin
          reg_in   = onehot(ra);
          done     = 1'b1;
          state_nx = start ? S_T0 : S_IDLE;
        end
`else
        reg_in   = onehot(ra);
        done     = 1'b1;
        state_nx = start ? S_T0 : S_IDLE;
`endif
      end
`ifdef RR_SEQ_MULDIV_EN
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        alu_op   = opcode;
        state_nx = start ? S_T0 : S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_alu_ctl_seq.sv
// Scoreboard bench for rr_alu_ctl_seq: per-state strobe checks plus a queue of expected done/err events.
`timescale 1ns/1ps
module tb_rr_alu_ctl_seq;

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_ZLOW   = 14'h1000;
  localparam logic [13:0] S_ZHIGH  = 14'h0800;
  localparam logic [13:0] S_MDROUT = 14'h0400;
  localparam logic [13:0] S_MARIN  = 14'h0200;
  localparam logic [13:0] S_ZIN    = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_MDRIN  = 14'h0040;
  localparam logic [13:0] S_IRIN   = 14'h0020;
  localparam logic [13:0] S_YIN    = 14'h0010;
  localparam logic [13:0] S_LOIN   = 14'h0008;
  localparam logic [13:0] S_HIIN   = 14'h0004;
  localparam logic [13:0] S_INCPC  = 14'h0002;
  localparam logic [13:0] S_READ   = 14'h0001;

  logic        Clock, clear, start, mem_rdy;
  logic [31:0] ir_in;
  logic        busy, done, err;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
  logic        IRin, Yin, LOin, HIin, IncPC, Read;
  logic [4:0]  alu_op;
  logic [15:0] reg_in, reg_out;

  rr_alu_ctl_seq dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir_in(ir_in),
    .busy(busy), .done(done), .err(err),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
    .alu_op(alu_op), .reg_in(reg_in), .reg_out(reg_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int at;
  } evt_t;

  evt_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] strobes();
    return {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
            IRin, Yin, LOin, HIin, IncPC, Read};
  endfunction

  task automatic push_evt(input bit is_err, input int at);
    evt_t e;
    e.is_err = is_err;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    evt_t e;
    if (done || err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {30'd0, done, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("evt_kind", 32'(err), 32'(e.is_err));
        check_eq("evt_cycle", 32'(cyc), 32'(e.at));
        check_eq("evt_done_and_err", 32'(done & err), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic idle_check(input string tag);
    check_eq({tag, "_strb"}, 32'(strobes()), 32'd0);
    check_eq({tag, "_regs"}, {reg_in, reg_out}, 32'd0);
    check_eq({tag, "_misc"}, 32'({busy, done, err, alu_op}), 32'd0);
  endtask

  task automatic run_alu(input logic [31:0] ir, input int ra, input int rb, input int rc,
                         input logic [4:0] op, input int stall, input bit poke_t2,
                         input string tag);
    int c0;
    c0      = cyc;
    ir_in   = ir;
    start   = 1'b1;
    mem_rdy = (stall == 0);
    push_evt(1'b0, c0 + 6 + stall);
    tick();
    start = 1'b0;
    check_eq({tag, "_t0"}, 32'(strobes()), 32'(S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
    check_eq({tag, "_t0_busy"}, 32'(busy), 32'd1);
    tick();
    check_eq({tag, "_t1"}, 32'(strobes()), 32'(S_ZLOW | S_PCIN | S_READ | S_MDRIN));
    for (int j = 1; j <= stall; j++) begin
      tick();
      check_eq({tag, "_t1w"}, 32'(strobes()), 32'(S_READ | S_MDRIN));
      check_eq({tag, "_t1w_busy"}, 32'(busy), 32'd1);
      mem_rdy = (j == stall);
    end
    tick();
    check_eq({tag, "_t2"}, 32'(strobes()), 32'(S_MDROUT | S_IRIN));
    if (poke_t2) start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_t3"}, 32'(strobes()), 32'(S_YIN));
    check_eq({tag, "_t3_rout"}, 32'(reg_out), 32'(16'd1 << rb));
    check_eq({tag, "_t3_op"}, 32'(alu_op), 32'd0);
    tick();
    check_eq({tag, "_t4"}, 32'(strobes()), 32'(S_ZIN));
    check_eq({tag, "_t4_rout"}, 32'(reg_out), 32'(16'd1 << rc));
    check_eq({tag, "_t4_op"}, 32'(alu_op), 32'(op));
    tick();
    check_eq({tag, "_t5"}, 32'(strobes()), 32'(S_ZLOW));
    check_eq({tag, "_t5_rin"}, {reg_in, reg_out}, {16'd1 << ra, 16'd0});
    check_eq({tag, "_t5_done"}, 32'(done), 32'd1);
    tick();
    idle_check({tag, "_end"});
  endtask

  task automatic run_bad(input logic [31:0] ir, input string tag);
    int c0;
    c0      = cyc;
    ir_in   = ir;
    start   = 1'b1;
    mem_rdy = 1'b1;
    push_evt(1'b1, c0 + 4);
    tick();
    start = 1'b0;
    check_eq({tag, "_t0"}, 32'(strobes()), 32'(S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
    tick();
    tick();
    check_eq({tag, "_t2_regs"}, {reg_in, reg_out}, 32'd0);
    tick();
    check_eq({tag, "_t3_err"}, 32'({busy, err, done}), 32'b110);
    check_eq({tag, "_t3_strb"}, 32'(strobes()), 32'd0);
    check_eq({tag, "_t3_regs"}, {reg_in, reg_out}, 32'd0);
    tick();
    idle_check({tag, "_end"});
  endtask

`ifdef RR_SEQ_MULDIV_EN
  task automatic run_muldiv(input logic [31:0] ir, input int ra, input int rb,
                            input logic [4:0] op, input string tag);
    int c0;
    c0      = cyc;
    ir_in   = ir;
    start   = 1'b1;
    mem_rdy = 1'b1;
    push_evt(1'b0, c0 + 7);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq({tag, "_t3"}, 32'(strobes()), 32'(S_YIN));
    check_eq({tag, "_t3_rout"}, 32'(reg_out), 32'(16'd1 << ra));
    tick();
    check_eq({tag, "_t4"}, 32'(strobes()), 32'(S_ZIN));
    check_eq({tag, "_t4_rout"}, 32'(reg_out), 32'(16'd1 << rb));
    check_eq({tag, "_t4_op"}, 32'(alu_op), 32'(op));
    tick();
    check_eq({tag, "_t5"}, 32'(strobes()), 32'(S_ZLOW | S_LOIN));
    check_eq({tag, "_t5_done"}, 32'({done, reg_in}), 32'd0);
    tick();
    check_eq({tag, "_t6"}, 32'(strobes()), 32'(S_ZHIGH | S_HIIN));
    check_eq({tag, "_t6_done"}, 32'({done, reg_in}), 32'h10000);
    tick();
    idle_check({tag, "_end"});
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          ra, rb, rc;
    logic [31:0] ir;
    int          bad_ops[$] = '{0, 1, 2, 12, 13, 14, 17, 24, 31};

    clear   = 1'b1;
    start   = 1'b0;
    mem_rdy = 1'b1;
    ir_in   = 32'd0;
    tick();
    tick();
    idle_check("reset");
    clear = 1'b0;

    run_alu(32'h20918000, 1, 2, 3, 5'b00100, 0, 1'b0, "sub");
    run_alu(32'h20918000, 1, 2, 3, 5'b00100, 3, 1'b0, "sub_stall3");
    run_bad(32'hF8000000, "ill_1f");

    // clear during T4 of add, then a full add afterwards
    ir_in = 32'h18918000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_eq("clr_t4_pre", 32'(reg_out), 32'h8);
    clear = 1'b1;
    tick();
    idle_check("clr_t4");
    clear = 1'b0;
    run_alu(32'h18918000, 1, 2, 3, 5'b00011, 0, 1'b0, "add_after_clr");

    run_alu(32'h20918000, 1, 2, 3, 5'b00100, 0, 1'b1, "sub_pokeT2");

    for (int op = 3; op <= 11; op++) begin
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rc = $urandom_range(0, 15);
      ir = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
      run_alu(ir, ra, rb, rc, 5'(op), $urandom_range(0, 2), 1'b0, "alu_tbl");
    end
    foreach (bad_ops[i]) begin
      ir = {5'(bad_ops[i]), 27'($urandom)};
      run_bad(ir, "ill_tbl");
    end

`ifdef RR_SEQ_MULDIV_EN
    run_muldiv(32'h7A280000, 4, 5, 5'b01111, "mul");
    run_muldiv(32'h80918000, 1, 2, 5'b10000, "div");
`else
    run_bad(32'h7A280000, "mul_off");
    run_bad(32'h80918000, "div_off");
`endif

    // start held through done: second T0 follows the T5 cycle directly
    c0      = cyc;
    ir_in   = 32'h28918000;
    mem_rdy = 1'b1;
    start   = 1'b1;
    push_evt(1'b0, c0 + 6);
    push_evt(1'b0, c0 + 12);
    repeat (6) tick();
    check_eq("b2b_t5_done", 32'({busy, done}), 32'b11);
    tick();
    check_eq("b2b_t0_again", 32'(strobes()), 32'(S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
    start = 1'b0;
    repeat (5) tick();
    check_eq("b2b_t5_done2", 32'(reg_in), 32'h2);
    tick();
    idle_check("b2b_end");

    // clear while stalled in T1W
    ir_in   = 32'h20918000;
    mem_rdy = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check_eq("clr_stall_pre", 32'(strobes()), 32'(S_READ | S_MDRIN));
    clear = 1'b1;
    tick();
    idle_check("clr_stall");
    clear   = 1'b0;
    mem_rdy = 1'b1;
    tick();
    check_eq("clr_stall_idle", 32'(busy), 32'd0);

    // clear and start together: clear wins
    clear = 1'b1;
    start = 1'b1;
    tick();
    idle_check("clr_start");
    clear = 1'b0;
    start = 1'b0;
    tick();
    check_eq("clr_start_idle", 32'(busy), 32'd0);

    repeat (4) tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
